capture_apb_fifo: RTL
=====================

CAPTURE_APB_FIFO -- requirements
Module: capture_apb_fifo

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 64, FIFO word depth; must be a power of two, 4..256.
REQ-002 SHALL use a single clock and a synchronous, active-low reset; all state changes on the rising edge of FCLK.
REQ-003 FCLK  in  1  fabric clock, same clock that drives the MSS fabric APB master.
REQ-004 M2FRESETn  in  1  synchronous active-low reset.
REQ-005 PSEL  in  1  APB select, from MSS fabric master.
REQ-006 PENABLE  in  1  APB access phase.
REQ-007 PWRITE  in  1  APB write when 1.
REQ-008 PADDR  in  8  byte address; bits [1:0] ignored.
REQ-009 PWDATA  in  32  APB write data.
REQ-010 PRDATA  out  32  APB read data.
REQ-011 PREADY  out  1  constant 1, zero wait states.
REQ-012 PSLVERR  out  1  APB error.
REQ-013 PIX_VALID  in  1  pixel strobe from the sensor front end.
REQ-014 PIX_DATA  in  8  pixel value.
REQ-015 PIX_SOF  in  1  start of frame, qualified by PIX_VALID.
REQ-016 FABINT  out  1  level interrupt to the MSS.

Function
REQ-017 An APB access SHALL be the cycle with PSEL=1 and PENABLE=1; PRDATA/PSLVERR are combinational in that cycle and 0 otherwise.
REQ-018 The register map SHALL be:
- 0x00 CTRL RW: [0] EN; [1] CLR, write-1 self-clearing, reads 0; [15:8] THRESH.
- 0x04 STATUS RO: [8:0] COUNT; [16] EMPTY; [17] FULL; [18] OVF, write-1-to-clear.
- 0x08 DATA RO: read pops one word.
- 0x0C FRAMES RO: [15:0] frame count.
REQ-019 Unmapped addresses SHALL read 0 with PSLVERR=0; writes to unmapped addresses or RO fields SHALL be ignored.
REQ-020 With EN=1, each PIX_VALID pixel SHALL be packed little-endian: the first pixel goes to [7:0], the fourth to [31:24].
REQ-021 On the fourth pixel, the word SHALL be pushed in that same clock edge.
REQ-022 A PIX_VALID pixel with PIX_SOF=1 SHALL discard any partial word, become lane 0, and increment FRAMES.
REQ-023 FRAMES SHALL wrap from 0xFFFF to 0.
REQ-024 With EN=0, pixels SHALL be ignored and the pack counter held; an existing partial word is kept.
REQ-025 A push with FIFO full and no simultaneous pop SHALL drop the word and set OVF sticky.
REQ-026 A DATA read with FIFO non-empty SHALL return the head word and advance the read pointer at the access edge.
REQ-027 A DATA read with FIFO empty SHALL return PRDATA=0 and PSLVERR=1, with no pointer change.
REQ-028 A push and a pop in the same cycle SHALL both complete and leave COUNT unchanged, including when full.
REQ-029 When empty, a same-cycle push and DATA read SHALL give an empty-read error while the push succeeds, leaving COUNT=1.
REQ-030 Pointers SHALL be log2(FIFO_DEPTH) bits and wrap modulo depth; COUNT ranges 0..FIFO_DEPTH.
REQ-031 A CLR write SHALL zero the pointers, COUNT, pack counter and OVF, and SHALL win over any push that cycle; FRAMES, EN and THRESH are unaffected.
REQ-032 FABINT SHALL be registered: FABINT <= (EN & THRESH!=0 & COUNT>=THRESH) | OVF, so it is 1 cycle after the condition.

Reset
REQ-033 While M2FRESETn=0 at a clock edge, the block SHALL clear EN, THRESH, OVF, pointers, COUNT, the pack counter, FRAMES and FABINT.
REQ-034 During reset, PRDATA=0, PSLVERR=0 and PREADY=1.
REQ-035 Reset asserted mid-packing or mid-APB transfer SHALL discard all state without a push or pop.

Verification
REQ-036 Bench SHALL cover these directed scenarios:
- EN=1, SOF then pixels 0x11,0x22,0x33,0x44 -> DATA read 0x44332211, PSLVERR=0; next DATA read PRDATA=0, PSLVERR=1.
- THRESH=4, push 4 words -> FABINT=1 one cycle after the 4th push; one DATA read -> FABINT=0 one cycle later.
- Fill 64 words, push a 65th -> COUNT=64, FULL=1, OVF=1, FABINT=1. Write 0x00040000 to STATUS -> OVF=0. Reads return the first 64 words in order.
- Full FIFO, 4th pixel coincides with a DATA read -> COUNT stays 64, OVF stays 0, the new word is read last.
- Two pixels, then SOF pixel 0xAA plus 0xBB,0xCC,0xDD -> head word 0xDDCCBBAA, FRAMES incremented by 1. Also: FRAMES at 0xFFFF plus SOF -> 0.
- 10 words queued, write CTRL=0x03 -> COUNT=0, EMPTY=1, EN stays 1. Separately: reset asserted after 2 pixels -> all STATUS fields read as reset values.

Source files
------------

// File: rtl/capture_apb_fifo.sv
// Pixel capture into a word FIFO, drained and controlled over a zero-wait APB slave.
// Four 8-bit pixels are packed little-endian into one 32-bit word; FABINT is a level interrupt.
module capture_apb_fifo #(
    parameter int FIFO_DEPTH = 64
) (
    input  logic        FCLK,
    input  logic        M2FRESETn,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [7:0]  PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    input  logic        PIX_VALID,
    input  logic [7:0]  PIX_DATA,
    input  logic        PIX_SOF,
    output logic        FABINT
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [5:0] A_CTRL   = 6'h00;
    localparam logic [5:0] A_STATUS = 6'h01;
    localparam logic [5:0] A_DATA   = 6'h02;
    localparam logic [5:0] A_FRAMES = 6'h03;

    logic          en;
    logic [7:0]    thresh;
    logic          ovf;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [8:0]    count9;
    logic [1:0]    pack_cnt;
    logic [23:0]   pack_word;
    logic [15:0]   frames;
    logic [31:0]   mem [FIFO_DEPTH];

    logic       access, wr_acc, rd_acc;
    logic [5:0] reg_idx;
    logic       empty, full;
    logic       pix_take, push_req, push_ok, drop, pop, clr;
    logic [1:0] pix_lane;
    logic       unused_bits;

    assign PREADY  = 1'b1;
    assign access  = PSEL & PENABLE;
    assign wr_acc  = access & PWRITE;
    assign rd_acc  = access & ~PWRITE;
    assign reg_idx = PADDR[7:2];
    assign count9  = 9'(count);
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(FIFO_DEPTH));

    // An SOF pixel always restarts packing at lane 0, dropping any partial word.
    assign pix_take = PIX_VALID & en;
    assign pix_lane = PIX_SOF ? 2'd0 : pack_cnt;
    assign push_req = pix_take & (pix_lane == 2'd3);
    assign pop      = rd_acc & (reg_idx == A_DATA) & ~empty;
    assign clr      = wr_acc & (reg_idx == A_CTRL) & PWDATA[1];
    assign push_ok  = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    assign unused_bits = ^{PADDR[1:0], PWDATA[31:19], PWDATA[17:16], PWDATA[7:2]};

    always_comb begin
        PRDATA  = '0;
        PSLVERR = 1'b0;
        if (rd_acc && M2FRESETn) begin
            case (reg_idx)
                A_CTRL:   PRDATA = {16'd0, thresh, 7'd0, en};
                A_STATUS: PRDATA = {13'd0, ovf, full, empty, 7'd0, count9};
                A_DATA: begin
                    if (empty) PSLVERR = 1'b1;
                    else       PRDATA  = mem[rd_ptr];
                end
                A_FRAMES: PRDATA = {16'd0, frames};
                default:  PRDATA = '0;
            endcase
        end
    end

    always_ff @(posedge FCLK) begin
        if (M2FRESETn && push_ok && !clr)
            mem[wr_ptr] <= {PIX_DATA, pack_word};
    end

    always_ff @(posedge FCLK) begin
        if (!M2FRESETn) begin
            en        <= 1'b0;
            thresh    <= '0;
            ovf       <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            pack_cnt  <= '0;
            pack_word <= '0;
            frames    <= '0;
            FABINT    <= 1'b0;
        end else begin
            if (wr_acc && reg_idx == A_CTRL) begin
                en     <= PWDATA[0];
                thresh <= PWDATA[15:8];
            end
            if (pix_take) begin
                pack_cnt <= pix_lane + 2'd1;
                case (pix_lane)
                    2'd0:    pack_word[7:0]   <= PIX_DATA;
                    2'd1:    pack_word[15:8]  <= PIX_DATA;
                    2'd2:    pack_word[23:16] <= PIX_DATA;
                    default: ;
                endcase
                if (PIX_SOF) frames <= frames + 16'd1;
            end
            if (drop)
                ovf <= 1'b1;
            else if (wr_acc && reg_idx == A_STATUS && PWDATA[18])
                ovf <= 1'b0;
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
            // Clear overrides any push or pop landing on the same edge.
            if (clr) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                pack_cnt <= '0;
                ovf      <= 1'b0;
            end
            FABINT <= (en && thresh != 8'd0 && count9 >= {1'b0, thresh}) || ovf;
        end
    end

endmodule
